rlbp_serial_capture: RTL and testbench

Downstream stage for the RLBP macro's parallel-to-serial output. Deserializes the RLBP serial bitstream back into 8-bit RLBP codes, buffers them in a small FIFO, and makes them readable by the management core over Wishbone. Sits beside the RLBP core inside the user-project area and shares its Wishbone clock and reset.

---
 rtl/rlbp_cap_pkg.sv | 50 +++++
 rtl/rlbp_cap_fifo.sv | 62 ++++++
 rtl/rlbp_serial_capture.sv | 181 ++++++++++++++++++
 tb/tb_rlbp_serial_capture.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlbp_cap_pkg.sv
// Shared definitions for the RLBP serial capture block: Wishbone register
// offsets, CTRL/STATUS/DATA bit positions and the STATUS word packer.
package rlbp_cap_pkg;

    // Word offsets taken from wbs_adr_i[3:2].
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_off_e;

    // CTRL fields.
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_THR_LSB    = 8;
    localparam int CTRL_THR_W      = 6;

    // STATUS fields.
    localparam int STAT_COUNT_LSB  = 0;
    localparam int STAT_COUNT_W    = 6;
    localparam int STAT_EMPTY_BIT  = 12;
    localparam int STAT_FULL_BIT   = 13;
    localparam int STAT_OVF_BIT    = 14;
    localparam int STAT_FERR_BIT   = 15;

    // DATA fields.
    localparam int DATA_VALID_BIT  = 31;

    typedef struct packed {
        logic       frame_err;
        logic       overflow;
        logic       full;
        logic       empty;
        logic [5:0] count;
    } status_t;

    // Place the status fields at their register bit positions.
    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w = '0;
        w[STAT_FERR_BIT]  = s.frame_err;
        w[STAT_OVF_BIT]   = s.overflow;
        w[STAT_FULL_BIT]  = s.full;
        w[STAT_EMPTY_BIT] = s.empty;
        w[STAT_COUNT_LSB +: STAT_COUNT_W] = s.count;
        return w;
    endfunction

endpackage

// File: rtl/rlbp_cap_fifo.sv
// Byte-wide synchronous FIFO for captured RLBP codes. DEPTH must be a power
// of two (2..32). A pop on empty is ignored; a push on full is ignored unless
// a pop happens in the same cycle. clear has priority over push/pop.
module rlbp_cap_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [5:0] count,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = 6'(level);

    // Storage write port.
    // NOTE: the data array has no reset; only pointers and level define
    // which entries are meaningful, so resetting storage would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rlbp_serial_capture.sv
// RLBP serial capture: deserializes the RLBP MSB-first bitstream into bytes,
// buffers them in rlbp_cap_fifo and exposes DATA/STATUS/CTRL over Wishbone.
// Optional FIFO-level interrupt output irq under macro RLBP_CAP_IRQ_EN.
module rlbp_serial_capture
    import rlbp_cap_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter logic [3:0] ADDR_NIBBLE = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_data,
    input  logic        ser_valid,
    input  logic        ser_sof,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
`ifdef RLBP_CAP_IRQ_EN
    ,
    output logic        irq
`endif
);
    logic       enable;
    logic [5:0] irq_thr;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt;
    logic       push_q;
    logic       overflow;
    logic       frame_err;

    logic [7:0] fifo_dout;
    logic [5:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;

    logic       wb_accept;
    logic       pop_req;
    logic       ctrl_wr;
    logic       clear_req;
    reg_off_e   reg_off;
    status_t    status;
    logic [31:0] rd_word;
    logic       unused_bits;

    assign reg_off   = reg_off_e'(wbs_adr_i[3:2]);
    assign wb_accept = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == ADDR_NIBBLE) & ~wbs_ack_o;
    assign pop_req   = wb_accept & ~wbs_we_i & (reg_off == REG_DATA);
    assign ctrl_wr   = wb_accept & wbs_we_i & (reg_off == REG_CTRL) & wbs_sel_i[0];
    assign clear_req = ctrl_wr & wbs_dat_i[CTRL_CLEAR_BIT];

    assign status = '{frame_err: frame_err, overflow: overflow, full: fifo_full,
                      empty: fifo_empty, count: fifo_count};

    assign unused_bits = ^{wbs_adr_i[27:4], wbs_adr_i[1:0], wbs_dat_i[31:14],
                           wbs_dat_i[13:8], wbs_dat_i[7:2], wbs_sel_i[3:1]};

    // Read mux: the word returned for an access accepted this cycle.
    // NOTE: rd_word gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_word = '0;
        case (reg_off)
            REG_DATA: begin
                if (!fifo_empty) begin
                    rd_word[DATA_VALID_BIT] = 1'b1;
                    rd_word[7:0]            = fifo_dout;
                end
            end
            REG_STATUS: rd_word = pack_status(status);
            REG_CTRL: begin
                rd_word[CTRL_ENABLE_BIT]             = enable;
                rd_word[CTRL_THR_LSB +: CTRL_THR_W]  = irq_thr;
            end
            default: rd_word = '0;
        endcase
    end

    // Wishbone response: one-cycle ack after acceptance, data latched at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_accept;
            wbs_dat_o <= (wb_accept && !wbs_we_i) ? rd_word : '0;
        end
    end

    // CTRL enable bit; clear is a pulse and never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable <= 1'b0;
        end else if (ctrl_wr) begin
            enable <= wbs_dat_i[CTRL_ENABLE_BIT];
        end
    end

`ifdef RLBP_CAP_IRQ_EN
    // Interrupt threshold; written only when both low byte lanes are selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_thr <= '0;
        end else if (ctrl_wr && wbs_sel_i[1]) begin
            irq_thr <= wbs_dat_i[CTRL_THR_LSB +: CTRL_THR_W];
        end
    end

    // Level interrupt, registered so it trails the count by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= enable && (irq_thr != '0) && (fifo_count >= irq_thr);
        end
    end
`else
    assign irq_thr = '0;
`endif

    // Assembler: positional MSB-first fill; a completed byte is pushed next cycle
    // straight from shift_q, which the following sof can overwrite at the same edge.
    always_ff @(posedge clk) begin
        if (rst || clear_req) begin
            shift_q <= '0;
            bit_cnt <= '0;
            push_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (!enable) begin
                bit_cnt <= '0;
            end else if (ser_valid) begin
                if (ser_sof) begin
                    shift_q <= {ser_data, 7'b0};
                    bit_cnt <= 3'd1;
                end else if (bit_cnt != 3'd0) begin
                    shift_q[3'd7 - bit_cnt] <= ser_data;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        push_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky error flags, cleared by reset or CTRL clear.
    always_ff @(posedge clk) begin
        if (rst || clear_req) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_q && fifo_full && !pop_req) begin
                overflow <= 1'b1;
            end
            if (enable && ser_valid && ser_sof && (bit_cnt != 3'd0)) begin
                frame_err <= 1'b1;
            end
        end
    end

    rlbp_cap_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_req),
        .push  (push_q),
        .pop   (pop_req),
        .din   (shift_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_rlbp_serial_capture.sv
// Self-checking bench for rlbp_serial_capture against a queue-based model.
// Irq checks are included when RLBP_CAP_IRQ_EN is defined.
module tb_rlbp_serial_capture;
    localparam int         DEPTH = 8;
    localparam logic [3:0] NIB   = 4'h4;
    localparam logic [1:0] O_DATA = 2'd0, O_STAT = 2'd1, O_CTRL = 2'd2, O_RSVD = 2'd3;
`ifdef RLBP_CAP_IRQ_EN
    localparam logic [31:0] CTRL_THR3 = 32'h0000_0301;
`else
    localparam logic [31:0] CTRL_THR3 = 32'h0000_0001;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_data = 1'b0, ser_valid = 1'b0, ser_sof = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
`ifdef RLBP_CAP_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    byte unsigned m_q[$];
    bit m_ovf = 0, m_ferr = 0;

    rlbp_serial_capture #(.DEPTH(DEPTH), .ADDR_NIBBLE(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_sof   (ser_sof),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o)
`ifdef RLBP_CAP_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: STATUS derived from queue occupancy and sticky flags.
    function automatic logic [31:0] m_status();
        logic [31:0] w;
        w = '0;
        w[15] = m_ferr;
        w[14] = m_ovf;
        w[13] = (m_q.size() == DEPTH);
        w[12] = (m_q.size() == 0);
        w[5:0] = 6'(m_q.size());
        return w;
    endfunction

    function automatic logic [31:0] m_pop();
        byte unsigned b;
        if (m_q.size() == 0) return 32'h0;
        b = m_q.pop_front();
        return {1'b1, 23'b0, b};
    endfunction

    function automatic void m_push(input byte unsigned b);
        if (m_q.size() == DEPTH) m_ovf = 1;
        else m_q.push_back(b);
    endfunction

    function automatic void m_clear();
        m_q.delete();
        m_ovf = 0;
        m_ferr = 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ser_valid = 1'b0;
            ser_sof   = 1'b0;
        end
    endtask

    // Drives n bits of b MSB first; the last bit stays on the bus until the next step.
    task automatic send_bits(input logic [7:0] b, input int n, input bit sof);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ser_valid = 1'b1;
            ser_data  = b[7-i];
            ser_sof   = sof && (i == 0);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] off, input logic [31:0] wdata,
                           input logic [3:0] sel, output logic [31:0] rdata);
        bit got;
        got = 0;
        rdata = '0;
        @(negedge clk);
        ser_valid = 1'b0;
        ser_sof   = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = {NIB, 24'h0, off, 2'b00};
        wbs_dat_i = wdata;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got = 1;
                rdata = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        check("wb_ack_seen", {31'b0, got}, 32'h1);
    endtask

    task automatic wb_read(input logic [1:0] off, output logic [31:0] rdata);
        wb_xfer(1'b0, off, 32'h0, 4'hF, rdata);
    endtask

    task automatic wb_write(input logic [1:0] off, input logic [31:0] wdata, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, wdata, sel, dummy);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  nb;
        int          op;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
`ifdef RLBP_CAP_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'h0);
`endif
        rst = 1'b0;
        wb_read(O_STAT, r); check("rst_status", r, 32'h0000_1000);
        wb_read(O_DATA, r); check("rst_data_empty", r, 32'h0);
        wb_read(O_CTRL, r); check("rst_ctrl", r, 32'h0);

        // Held strobe: ack every other cycle.
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = {NIB, 24'h0, O_STAT, 2'b00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_ack", {31'b0, wbs_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

        // Bits while disabled are ignored.
        send_bits(8'h5A, 8, 1); idle(3);
        wb_read(O_STAT, r); check("disabled_ignored", r, m_status());

        // Enable; latency of first byte.
        wb_write(O_CTRL, 32'h1, 4'hF);
        send_bits(8'hA5, 8, 1);
        wb_read(O_STAT, r); check("lat_n1_not_yet", r, m_status());
        m_push(8'hA5);
        wb_read(O_STAT, r); check("a5_status", r, m_status());
        wb_read(O_DATA, r); check("a5_data", r, m_pop());
        wb_read(O_STAT, r); check("a5_empty_after", r, m_status());
        b = 8'($urandom);
        send_bits(b, 8, 1); idle(1);
        m_push(b);
        wb_read(O_STAT, r); check("lat_n2_count", r, m_status());
        wb_read(O_DATA, r); check("lat_n2_data", r, m_pop());

        // Bits without sof are discarded.
        send_bits(8'($urandom), 8, 0); idle(3);
        wb_read(O_STAT, r); check("no_sof_discard", r, m_status());

        // Frame error then clear.
        send_bits(8'hFF, 4, 1);
        send_bits(8'h3C, 8, 1); idle(3);
        m_ferr = 1; m_push(8'h3C);
        wb_read(O_STAT, r); check("ferr_status", r, m_status());
        wb_read(O_DATA, r); check("ferr_data", r, m_pop());
        wb_read(O_DATA, r); check("ferr_only_one", r, m_pop());
        wb_write(O_CTRL, 32'h3, 4'hF); m_clear();
        wb_read(O_STAT, r); check("clear_status", r, m_status());
        wb_read(O_CTRL, r); check("ctrl_clear_selfclr", r, 32'h1);

        // Overflow with nine bytes.
        for (int i = 1; i <= 9; i++) begin
            send_bits(8'(i), 8, 1);
            m_push(8'(i));
        end
        idle(3);
        wb_read(O_STAT, r); check("ovf_status", r, m_status());
        for (int i = 0; i < 8; i++) begin
            wb_read(O_DATA, r); check("ovf_drain", r, m_pop());
        end
        wb_read(O_STAT, r); check("ovf_sticky", r, m_status());

        // Full FIFO: byte push and DATA pop in the same cycle.
        wb_write(O_CTRL, 32'h3, 4'hF); m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_bits(b, 8, 1);
            m_push(b);
        end
        idle(3);
        wb_read(O_STAT, r); check("full_status", r, m_status());
        nb = 8'($urandom);
        send_bits(nb, 8, 1);
        wb_read(O_DATA, r); check("full_pushpop_data", r, m_pop());
        m_push(nb);
        idle(2);
        wb_read(O_STAT, r); check("full_pushpop_status", r, m_status());
        for (int i = 0; i < DEPTH; i++) begin
            wb_read(O_DATA, r); check("full_drain", r, m_pop());
        end
        wb_read(O_DATA, r); check("drained_empty", r, 32'h0);

        // Disable discards a partial byte; no spurious frame error afterwards.
        send_bits(8'hF0, 4, 1);
        wb_write(O_CTRL, 32'h0, 4'hF);
        wb_write(O_CTRL, 32'h1, 4'hF);
        send_bits(8'hFF, 4, 0);
        b = 8'($urandom);
        send_bits(b, 8, 1); idle(3);
        m_push(b);
        wb_read(O_STAT, r); check("disable_partial_status", r, m_status());
        wb_read(O_DATA, r); check("disable_partial_data", r, m_pop());

        // Ignored writes.
        wb_write(O_RSVD, 32'hFFFF_FFFF, 4'hF);
        wb_read(O_RSVD, r); check("rsvd_reads_zero", r, 32'h0);
        wb_write(O_DATA, 32'h0000_00FF, 4'hF);
        wb_read(O_STAT, r); check("data_write_ignored", r, m_status());
        wb_write(O_CTRL, 32'h0, 4'hE);
        wb_read(O_CTRL, r); check("ctrl_sel0_gate", r, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                b = 8'($urandom);
                send_bits(b, 8, 1); idle(2);
                m_push(b);
            end else if (op == 1) begin
                wb_read(O_DATA, r); check("rand_data", r, m_pop());
            end else begin
                wb_read(O_STAT, r); check("rand_status", r, m_status());
            end
        end

        // Threshold field.
        wb_write(O_CTRL, 32'h0000_0303, 4'hF); m_clear();
        wb_read(O_CTRL, r); check("ctrl_thr", r, CTRL_THR3);
        wb_write(O_CTRL, 32'h0000_0501, 4'h1);
        wb_read(O_CTRL, r); check("ctrl_thr_sel1_gate", r, CTRL_THR3);

        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_bits(b, 8, 1);
            m_push(b);
        end
        b = 8'($urandom);
        send_bits(b, 8, 1);
        m_push(b);
        idle(1);
`ifdef RLBP_CAP_IRQ_EN
        @(negedge clk);
        check("irq_low_at_land", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'b0, irq}, 32'h1);
        wb_read(O_DATA, r); check("irq_pop_data", r, m_pop());
        check("irq_still_high", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'b0, irq}, 32'h0);
`else
        idle(2);
        wb_read(O_DATA, r); check("pre_rst_pop", r, m_pop());
`endif
        b = 8'($urandom);
        send_bits(b, 8, 1); idle(3);
        m_push(b);
        wb_read(O_STAT, r); check("pre_rst_status", r, m_status());

        // Reset mid-byte and mid-transaction.
        send_bits(8'hC3, 4, 1);
        @(negedge clk);
        ser_valid = 1'b0; ser_sof = 1'b0;
        rst = 1'b1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = {NIB, 24'h0, O_DATA, 2'b00};
        @(negedge clk);
        check("midrst_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("midrst_dat", wbs_dat_o, 32'h0);
`ifdef RLBP_CAP_IRQ_EN
        check("midrst_irq", {31'b0, irq}, 32'h0);
`endif
        rst = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        m_clear();
        @(negedge clk);
        check("midrst_no_ack", {31'b0, wbs_ack_o}, 32'h0);
        wb_read(O_STAT, r); check("midrst_status", r, m_status());
        wb_read(O_CTRL, r); check("midrst_ctrl", r, 32'h0);
        wb_read(O_DATA, r); check("midrst_data", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
